lut_layer_sequencer: RTL and testbench
======================================

# lut_layer_sequencer

Time-multiplexed evaluator for one layer of 6-input, 1-output truth-table neurons. A single shared lookup engine walks all neurons of the layer serially over a registered input vector. It assembles the layer's output vector and hands it on through a valid/ready handshake. Truth tables are runtime-programmable through a config port, so one netlist serves any trained layer of the same shape. It sits between two layer-level valid/ready stages in the inference pipeline.

## Interface
- `IN_BITS`, default 64: input vector width.
- `NEURONS`, default 16: neurons in the layer, 2 to 256.
- `FAN_IN`, default 6: inputs per neuron; table depth is 2^FAN_IN.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: input vector valid.
- `s_ready` out 1: sequencer can accept a vector.
- `s_data` in IN_BITS: input vector.
- `m_valid` out 1: output vector valid.
- `m_ready` in 1: downstream accepts the output.
- `m_data` out NEURONS: bit n is neuron n's output.
- `cfg_we` in 1: write one truth-table bit.
- `cfg_addr` in clog2(NEURONS·2^FAN_IN): equals neuron·2^FAN_IN + table index.
- `cfg_bit` in 1: value to write.
- `cfg_ready` out 1: config writes are accepted this cycle.
- `busy` out 1: high in RUN or DONE.

## Operation
- Connectivity is fixed. Input j of neuron n = `s_data[(n·FAN_IN + j) mod IN_BITS]`.
- Table index = concatenation {in[FAN_IN-1],…,in[0]}, with input 0 as the LSB.
- Table storage is NEURONS·2^FAN_IN flops. All bits clear to 0 on reset.
- FSM states:
  - IDLE: `s_ready`=1, `cfg_ready`=1. On `s_valid`, capture `s_data` into `in_reg`, clear `nidx`, clear the output shift register, go to RUN.
  - RUN: each cycle, look up neuron `nidx` from `in_reg` and its table, write the result to `m_data` bit `nidx`, then increment `nidx`. The cycle with `nidx`=NEURONS-1 moves to DONE.
  - DONE: `m_valid`=1 and `m_data` stable. On `m_ready`, go to IDLE.
- Config:
  - `cfg_we` is honoured only when `cfg_ready`=1. It is ignored in RUN and DONE; writers must qualify on `cfg_ready`.
  - `cfg_addr` ≥ NEURONS·2^FAN_IN is ignored.
  - If `cfg_we` and `s_valid` arrive in the same IDLE cycle, both take effect. The write lands at that same edge, so the new bit is visible to the evaluation that starts.
- Reset values: `s_ready`=1, `cfg_ready`=1, `m_valid`=0, `m_data`=0, `busy`=0, state IDLE, `nidx`=0.
- Reset asserted mid-RUN or mid-DONE: abandon the evaluation, drop `m_valid` immediately, clear tables.

## Timing
- Input is accepted on the edge where `s_valid`&`s_ready`. Call that edge E.
- `m_valid` rises after edge E+NEURONS, so latency is NEURONS cycles.
- `m_valid` falls on the edge where `m_ready`=1. `s_ready` is 1 in the following cycle.
- Minimum initiation interval with `m_ready` tied high: NEURONS+2 cycles.
- No combinational path from `s_valid` or `m_ready` to any output. `s_ready`, `cfg_ready`, `m_valid` and `busy` decode from registered state only.
- `nidx` width is clog2(NEURONS). It never wraps past NEURONS-1.
- `m_data` bits above `nidx` read 0 during RUN.
- `m_data` is undefined to consumers unless `m_valid`=1.

## Structure
- Package `lut_layer_pkg` holds:
  - the state enum {IDLE, RUN, DONE};
  - function `fanin_index(n, j)`;
  - localparams for table depth and address width.
- One sub-module, `lut_table_bank`, holds:
  - the flop array and write port;
  - a combinational read of (neuron, index) returning 1 bit.
- The sequencer owns the FSM, `in_reg`, `nidx` and the output register.

## Test plan
Scenarios use NEURONS=4, IN_BITS=24, FAN_IN=6 unless noted.
- Reset, then idle: no stimulus → `s_ready`=1, `cfg_ready`=1, `m_valid`=0, `m_data`=0, `busy`=0. With all tables zero, vector 0xFFFFFF → `m_data`=0x0 exactly 4 cycles after accept.
- Parity tables: program every entry as the parity of its index. `s_data`=0x00003F → `m_data`=0x0. `s_data`=0x000001 → `m_data`=0x1. `s_data`=0x820820 → `m_data`=0xF.
- Backpressure: hold `m_ready`=0 for 10 cycles after `m_valid`. Require `m_data` stable, `s_ready`=0, and a second `s_valid` not accepted. Raise `m_ready` → the second vector is accepted in the cycle after `m_valid` falls.
- Config lockout: during RUN, pulse `cfg_we` to addr 0 with value 1. Then `s_data`=0 → neuron 0 output stays 0 on that run and on the next. The same write in IDLE → the next run gives `m_data`[0]=1.
- Out-of-range write: `cfg_addr`=256 with NEURONS=4 → no table bit changes, verified by a full readback sweep through evaluations.
- Reset mid-RUN: assert `rst_n`=0 two cycles after accept → outputs go to reset values at once. After release, a vector 0xFFFFFF → `m_data`=0x0, confirming the tables were cleared.

Source files
------------

// File: rtl/lut_layer_sequencer_pkg.sv
// Shared types, sizing helpers and fixed connectivity for the LUT layer sequencer.
package lut_layer_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Default layer shape.
  localparam int DEF_IN_BITS     = 64;
  localparam int DEF_NEURONS     = 16;
  localparam int DEF_FAN_IN      = 6;
  localparam int DEF_TABLE_DEPTH = 2 ** DEF_FAN_IN;
  // One extra code point beyond the table so an out-of-range address is
  // always expressible on the config port and can be rejected.
  localparam int DEF_CFG_AW      = $clog2(DEF_NEURONS * DEF_TABLE_DEPTH + 1);

  // Truth-table depth for a given fan-in.
  function automatic int table_depth(input int fan_in);
    return 2 ** fan_in;
  endfunction

  // Config address width for a given layer shape.
  function automatic int cfg_addr_w(input int neurons, input int fan_in);
    return $clog2(neurons * (2 ** fan_in) + 1);
  endfunction

  // Input-vector bit feeding input j of neuron n.
  function automatic int fanin_index(input int n, input int j, input int fan_in, input int in_bits);
    return (n * fan_in + j) % in_bits;
  endfunction

endpackage

// File: rtl/lut_layer_sequencer_if.sv
// Layer-level valid/ready stream bundle: input vector in, neuron outputs out.
interface lut_layer_sequencer_if
  import lut_layer_pkg::*;
#(
  parameter int IN_BITS = DEF_IN_BITS,
  parameter int NEURONS = DEF_NEURONS
) ();

  logic               s_valid;
  logic               s_ready;
  logic [IN_BITS-1:0] s_data;
  logic               m_valid;
  logic               m_ready;
  logic [NEURONS-1:0] m_data;

  // Environment side: produces input vectors, consumes output vectors.
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  // Sequencer side.
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/lut_layer_sequencer_bank.sv
// Truth-table storage: one bit per (neuron, index), single write port,
// combinational single-bit read.
module lut_table_bank
  import lut_layer_pkg::*;
#(
  parameter int NEURONS = DEF_NEURONS,
  parameter int FAN_IN  = DEF_FAN_IN,
  parameter int NIDX_W  = $clog2(NEURONS),
  parameter int CFG_AW  = cfg_addr_w(NEURONS, FAN_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CFG_AW-1:0] wr_addr,
  input  logic              wr_bit,
  input  logic [NIDX_W-1:0] rd_neuron,
  input  logic [FAN_IN-1:0] rd_index,
  output logic              rd_bit
);

  localparam int DEPTH  = table_depth(FAN_IN);
  localparam int TOTAL  = NEURONS * DEPTH;
  localparam int BIT_AW = $clog2(TOTAL);

  logic [TOTAL-1:0] bits_q;
  logic [TOTAL-1:0] bits_d;

  // Apply a write only when enabled and the address lands inside the table.
  always_comb begin
    bits_d = bits_q;
    if (wr_en && (wr_addr < CFG_AW'(TOTAL))) begin
      bits_d[wr_addr[BIT_AW-1:0]] = wr_bit;
    end else begin
      bits_d = bits_q;
    end
  end

  // Table flops; every entry clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q <= {TOTAL{1'b0}};
    end else begin
      bits_q <= bits_d;
    end
  end

  // Depth is a power of two, so {neuron, index} is the flat address.
  assign rd_bit = bits_q[{rd_neuron, rd_index}];

endmodule

// File: rtl/lut_layer_sequencer.sv
// Serial evaluator for one layer of FAN_IN-input truth-table neurons: latches
// an input vector, walks every neuron through a shared table lookup, and
// presents the assembled output vector on a valid/ready handshake.
module lut_layer_sequencer
  import lut_layer_pkg::*;
#(
  parameter int IN_BITS = DEF_IN_BITS,
  parameter int NEURONS = DEF_NEURONS,
  parameter int FAN_IN  = DEF_FAN_IN,
  parameter int CFG_AW  = cfg_addr_w(NEURONS, FAN_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lut_layer_sequencer_if.slave   bus,
  input  logic                   cfg_we,
  input  logic [CFG_AW-1:0]      cfg_addr,
  input  logic                   cfg_bit,
  output logic                   cfg_ready,
  output logic                   busy
);

  localparam int NIDX_W = $clog2(NEURONS);
  localparam logic [NIDX_W-1:0] LAST_NIDX = NIDX_W'(NEURONS - 1);

  seq_state_e         state_q, state_d;
  logic [IN_BITS-1:0] in_reg_q, in_reg_d;
  logic [NIDX_W-1:0]  nidx_q, nidx_d;
  logic [NEURONS-1:0] m_data_q, m_data_d;

  logic [NEURONS-1:0][FAN_IN-1:0] taps_s;
  logic [FAN_IN-1:0]              lut_index_s;
  logic                           lut_bit_s;
  logic                           idle_s;

  // Fixed wiring: gather each neuron's inputs from the latched vector.
  for (genvar gn = 0; gn < NEURONS; gn++) begin : g_neuron
    for (genvar gj = 0; gj < FAN_IN; gj++) begin : g_tap
      assign taps_s[gn][gj] = in_reg_q[fanin_index(gn, gj, FAN_IN, IN_BITS)];
    end
  end

  assign lut_index_s = taps_s[nidx_q];
  assign idle_s      = (state_q == IDLE);

  lut_table_bank #(
    .NEURONS (NEURONS),
    .FAN_IN  (FAN_IN),
    .NIDX_W  (NIDX_W),
    .CFG_AW  (CFG_AW)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (cfg_we & idle_s),
    .wr_addr   (cfg_addr),
    .wr_bit    (cfg_bit),
    .rd_neuron (nidx_q),
    .rd_index  (lut_index_s),
    .rd_bit    (lut_bit_s)
  );

  // Next-state and datapath updates for accept / walk / hand-off.
  always_comb begin
    state_d  = state_q;
    in_reg_d = in_reg_q;
    nidx_d   = nidx_q;
    m_data_d = m_data_q;
    case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          in_reg_d = bus.s_data;
          nidx_d   = {NIDX_W{1'b0}};
          m_data_d = {NEURONS{1'b0}};
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        m_data_d[nidx_q] = lut_bit_s;
        if (nidx_q == LAST_NIDX) begin
          state_d = DONE;
        end else begin
          nidx_d  = nidx_q + NIDX_W'(1'b1);
        end
      end
      DONE: begin
        if (bus.m_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state, latched vector, neuron counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      in_reg_q <= {IN_BITS{1'b0}};
      nidx_q   <= {NIDX_W{1'b0}};
      m_data_q <= {NEURONS{1'b0}};
    end else begin
      state_q  <= state_d;
      in_reg_q <= in_reg_d;
      nidx_q   <= nidx_d;
      m_data_q <= m_data_d;
    end
  end

  assign bus.s_ready = idle_s;
  assign cfg_ready   = idle_s;
  assign bus.m_valid = (state_q == DONE);
  assign busy        = (state_q == RUN) || (state_q == DONE);
  assign bus.m_data  = m_data_q;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Directed bench for lut_layer_sequencer with NEURONS=4, IN_BITS=24, FAN_IN=6.
module tb_lut_layer_sequencer;

  localparam int IN_BITS = 24;
  localparam int NEURONS = 4;
  localparam int FAN_IN  = 6;
  localparam int CFG_AW  = 9;

  logic              clk;
  logic              rst_n;
  logic              cfg_we;
  logic [CFG_AW-1:0] cfg_addr;
  logic              cfg_bit;
  logic              cfg_ready;
  logic              busy;

  int n_cmp;
  int n_bad;

  lut_layer_sequencer_if #(.IN_BITS(IN_BITS), .NEURONS(NEURONS)) bus ();

  lut_layer_sequencer #(
    .IN_BITS (IN_BITS),
    .NEURONS (NEURONS),
    .FAN_IN  (FAN_IN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [CFG_AW-1:0] a, input logic b);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_bit  = b;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Present a vector and hold it until the accepting edge has passed.
  task automatic accept(input logic [IN_BITS-1:0] v);
    int n;
    n = 0;
    while (!bus.s_ready && n < 40) begin
      tick();
      n++;
    end
    check_eq("s_ready_wait", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.m_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic drain();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [IN_BITS-1:0] v, input logic [31:0] exp);
    int cyc;
    accept(v);
    wait_valid(cyc);
    check_eq({tag, "_lat"}, 32'(cyc), 32'd4);
    check_eq(tag, 32'(bus.m_data), exp);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          bad;
    logic [8:0]  av;
    logic [5:0]  ix;

    n_cmp       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    cfg_we      = 1'b0;
    cfg_addr    = 9'd0;
    cfg_bit     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 24'd0;
    bus.m_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state.
    check_eq("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check_eq("rst_m_data", 32'(bus.m_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // Empty tables: all-ones vector gives zero after exactly 4 cycles.
    accept(24'hFFFFFF);
    check_eq("run_busy", 32'(busy), 32'd1);
    check_eq("run_s_ready", 32'(bus.s_ready), 32'd0);
    check_eq("run_cfg_ready", 32'(cfg_ready), 32'd0);
    check_eq("run_m_valid", 32'(bus.m_valid), 32'd0);
    wait_valid(cyc);
    check_eq("zero_lat", 32'(cyc), 32'd4);
    check_eq("zero_data", 32'(bus.m_data), 32'd0);
    drain();
    check_eq("drain_m_valid", 32'(bus.m_valid), 32'd0);
    check_eq("drain_s_ready", 32'(bus.s_ready), 32'd1);

    // Parity tables.
    for (int a = 0; a < 256; a++) begin
      av = 9'(a);
      cfg_write(av, ^av[5:0]);
    end
    run_vec("par_3f", 24'h00003F, 32'h0);
    run_vec("par_01", 24'h000001, 32'h1);
    run_vec("par_107", 24'h000107, 32'h3);

    // Partial result mid-walk: only neuron 0 written, upper bits still 0.
    accept(24'h820820);
    tick();
    check_eq("mid_upper_zero", 32'(bus.m_data), 32'h1);
    wait_valid(cyc);
    check_eq("par_820820", 32'(bus.m_data), 32'hF);
    drain();

    // Input ordering: neuron 1 input 0 is index bit 0, input 5 is bit 5.
    cfg_write(9'd65, 1'b0);
    run_vec("ord_in0", 24'h000040, 32'h0);
    run_vec("ord_in5", 24'h000800, 32'h2);
    cfg_write(9'd65, 1'b1);
    run_vec("ord_restore", 24'h000040, 32'h2);

    // Backpressure: result held, second vector refused until drained.
    accept(24'h000001);
    wait_valid(cyc);
    check_eq("bp_lat", 32'(cyc), 32'd4);
    bus.s_valid = 1'b1;
    bus.s_data  = 24'h820820;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.m_data !== 4'h1 || bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0) bad++;
    end
    check_eq("bp_hold", 32'(bad), 32'd0);
    check_eq("bp_data", 32'(bus.m_data), 32'h1);
    check_eq("bp_s_ready", 32'(bus.s_ready), 32'd0);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check_eq("bp_fall_m_valid", 32'(bus.m_valid), 32'd0);
    check_eq("bp_fall_s_ready", 32'(bus.s_ready), 32'd1);
    tick();
    bus.s_valid = 1'b0;
    check_eq("bp_second_busy", 32'(busy), 32'd1);
    wait_valid(cyc);
    check_eq("bp_second_lat", 32'(cyc), 32'd4);
    check_eq("bp_second_data", 32'(bus.m_data), 32'hF);
    drain();

    // Config lockout: a write during RUN is dropped.
    accept(24'h000000);
    tick();
    cfg_write(9'd0, 1'b1);
    wait_valid(cyc);
    check_eq("lock_run", 32'(bus.m_data), 32'h0);
    drain();
    run_vec("lock_next", 24'h000000, 32'h0);
    cfg_write(9'd0, 1'b1);
    run_vec("cfg_idle", 24'h000000, 32'h1);

    // Write and accept on the same edge: evaluation sees the new bit.
    cfg_we   = 1'b1;
    cfg_addr = 9'd0;
    cfg_bit  = 1'b0;
    accept(24'h000000);
    cfg_we   = 1'b0;
    wait_valid(cyc);
    check_eq("same_edge_lat", 32'(cyc), 32'd4);
    check_eq("same_edge", 32'(bus.m_data), 32'h0);
    drain();

    // Out-of-range writes, then sweep every index across all four neurons.
    cfg_write(9'd256, 1'b1);
    cfg_write(9'd511, 1'b1);
    for (int i = 0; i < 64; i++) begin
      ix = 6'(i);
      run_vec("sweep", {ix, ix, ix, ix}, (^ix) ? 32'hF : 32'h0);
    end

    // Reset during RUN: outputs return to reset values immediately.
    accept(24'h820820);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("arst_m_valid", 32'(bus.m_valid), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_s_ready", 32'(bus.s_ready), 32'd1);
    check_eq("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_eq("arst_m_data", 32'(bus.m_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_vec("post_rst_ff", 24'hFFFFFF, 32'h0);
    run_vec("post_rst_820", 24'h820820, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
